// File: rtl/trng_conditioner.sv
// TRNG conditioning stage: repetition-count health test, optional von Neumann
// debiasing, WIDTH-bit word packing and a DEPTH-entry show-ahead output FIFO.
module trng_conditioner #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned REP_LIMIT = 16,
  parameter int unsigned DEBIAS    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       raw_bit,
  input  logic                       raw_valid,
  input  logic                       health_clr,
  output logic [WIDTH-1:0]           rnd_word,
  output logic                       rnd_valid,
  input  logic                       rnd_ready,
  output logic                       health_fail,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  logic             accept;
  logic             rep_last;
  logic [7:0]       rep_cnt;
  logic [7:0]       rep_next;
  logic             pair_flag;
  logic             pair_first;
  logic             cond_valid;
  logic             cond_bit;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_next;
  logic [CW-1:0]    bit_cnt;
  logic             word_done;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [FW-1:0]    count;
  logic             full;
  logic             pop;
  logic             push;

  assign accept = raw_valid & enable & ~health_fail & ~health_clr;

  // rep_cnt == 0 marks "no previous sample" after reset or clear
  always_comb begin
    rep_next = 8'd1;
    if (rep_cnt != '0 && raw_bit == rep_last)
      rep_next = rep_cnt + 8'd1;
  end

  always_comb begin
    cond_valid = 1'b0;
    cond_bit   = 1'b0;
    if (DEBIAS != 0) begin
      cond_valid = accept & pair_flag & (pair_first != raw_bit);
      cond_bit   = pair_first;
    end else begin
      cond_valid = accept;
      cond_bit   = raw_bit;
    end
  end

  assign word_next = {shreg[WIDTH-2:0], cond_bit};
  assign word_done = cond_valid && (bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst || health_clr) begin
      health_fail <= 1'b0;
      rep_last    <= 1'b0;
      rep_cnt     <= '0;
      pair_flag   <= 1'b0;
      pair_first  <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
    end else if (accept) begin
      rep_last <= raw_bit;
      rep_cnt  <= rep_next;
      if (rep_next == 8'(REP_LIMIT))
        health_fail <= 1'b1;
      pair_flag <= ~pair_flag;
      if (!pair_flag)
        pair_first <= raw_bit;
      if (cond_valid) begin
        shreg   <= word_next;
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  assign full      = (count == FW'(DEPTH));
  assign rnd_valid = (count != '0);
  assign pop       = rnd_valid & rnd_ready;
  // a full FIFO still takes a word when the head leaves in the same cycle
  assign push      = word_done & (~full | pop);
  assign rnd_word  = mem[rd_ptr];
  assign fill_level = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= word_done & full & ~pop;
      if (push) begin
        mem[wr_ptr] <= word_next;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

endmodule
